bcd_display_scanner: RTL

Time-multiplexed 7-segment display driver that consumes packed BCD digits from the decade counters and drives a common segment bus plus one-hot digit enables. Digits are captured on a load strobe, held in a local latch, and scanned one at a time at a programmable refresh rate. It sits between the BCD counter chain and the board's display pins.

---
 rtl/bcd_display_scanner_pkg.sv | 37 +++
 rtl/bcd_to_seg.sv | 15 +
 rtl/bcd_display_scanner.sv | 104 ++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared segment constants and the BCD-to-7-segment decode used by the display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_display_scanner_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes 10..15 are not BCD and show a centre dash.
  function automatic logic [6:0] bcd_decode(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit decoder: segment pattern plus a flag for non-BCD codes.
module bcd_to_seg
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg,
  output logic       invalid
);

  always_comb begin
    seg     = bcd_decode(bcd);
    invalid = (bcd > 4'd9);
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner: latches packed BCD on L and cycles one-hot digit enables.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  P,
  input  logic                  R,
  input  logic                  L,
  input  logic [4*N_DIGITS-1:0] D,
  output logic [6:0]            S,
  output logic [N_DIGITS-1:0]   A,
  output logic                  E
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] latch_q, latch_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  err_q, err_d;

  logic [N_DIGITS-1:0]   blank_mask;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            dec_seg;
  logic                  dec_invalid;

  always_comb begin
    blank_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin : g_blank
      logic all_zero;
      all_zero = 1'b1;
      // Walk down from the top digit; a digit blanks only while everything above it is zero too.
      for (int i = N_DIGITS - 1; i > 0; i--) begin
        all_zero      = all_zero & (latch_q[4*i +: 4] == 4'd0);
        blank_mask[i] = all_zero;
      end
    end
`endif
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_d      = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = latch_q[4*i +: 4];
        cur_blank = blank_mask[i];
        an_d[i]   = 1'b1;
      end
    end
  end

  bcd_to_seg u_dec (
    .bcd     (cur_digit),
    .seg     (dec_seg),
    .invalid (dec_invalid)
  );

  always_comb begin
    div_d   = div_q + DIV_W'(1);
    idx_d   = idx_q;
    latch_d = L ? D : latch_q;
    seg_d   = cur_blank ? SEG_BLANK : dec_seg;
    err_d   = dec_invalid & ~cur_blank;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge P) begin
    if (R) begin
      latch_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      latch_q <= latch_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      err_q   <= err_d;
    end
  end

  assign S = seg_q;
  assign A = an_q;
  assign E = err_q;

endmodule
